// File: rtl/fpu_seq_pkg.sv
// Shared types and sizing constants for the FPU dot-product sequencer.
package fpu_seq_pkg;

  localparam int unsigned SEQ_WORD_W = 32;
  localparam int unsigned SEQ_N_OPER = 4;
  localparam int unsigned BYTES_IN   = SEQ_N_OPER * SEQ_WORD_W / 8;
  localparam int unsigned BYTES_OUT  = SEQ_WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    CAPTURE,
    SEND
  } seq_state_t;

endpackage

// File: rtl/fpu_seq_byte_serializer.sv
// SEND-stage serializer: holds one result word and streams it out LSB byte
// first over a valid/ready handshake. 'done' flags the final accepted byte.
module fpu_seq_byte_serializer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned WORD_W = SEQ_WORD_W
) (
  input  logic              clk,
  input  logic              write_data_reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  input  logic              out_ready,
  output logic              done
);

  localparam int unsigned NB    = WORD_W / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              active_q;

  // Capture the word on load, then step the byte index on each accepted byte.
  always_ff @(posedge clk or posedge write_data_reset) begin
    if (write_data_reset) begin
      word_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      word_q   <= data;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && out_ready) begin
      idx_q <= idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        active_q <= 1'b0;
      end
    end
  end

  assign out_valid = active_q;
  assign out_byte  = word_q[{idx_q, 3'b000} +: 8];
  assign done      = active_q && out_ready && (idx_q == LAST_IDX);

endmodule

// File: rtl/fpu_dot_sequencer.sv
// Job-based controller for one dot-product (I1*I2 + I3*I4) on the shared FPU:
// collects 16 operand bytes, launches the FPU, waits its fixed latency,
// captures the result and streams it back as 4 bytes.
// Optional build macro: FPU_DOT_SEQ_WATCHDOG_EN (abort stalled partial loads).
module fpu_dot_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned WORD_W      = SEQ_WORD_W,
  parameter int unsigned N_OPER      = SEQ_N_OPER,
  parameter int unsigned FPU_LATENCY = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       write_data_reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  output logic                       in_ready,
  output logic [N_OPER*WORD_W-1:0]   fpu_operands,
  output logic                       fpu_launch,
  input  logic [WORD_W-1:0]          fpu_result,
  output logic                       out_valid,
  output logic [7:0]                 out_byte,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned LAT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

  // Byte counter and operand indexing are sized for a 16-byte / 4-byte job.
  if (N_OPER * WORD_W / 8 != BYTES_IN) begin : g_bad_in_size
    $error("fpu_dot_sequencer: operand width must be %0d bytes", BYTES_IN);
  end
  if (WORD_W / 8 != BYTES_OUT) begin : g_bad_out_size
    $error("fpu_dot_sequencer: result width must be %0d bytes", BYTES_OUT);
  end
  if (FPU_LATENCY < 1) begin : g_bad_latency
    $error("fpu_dot_sequencer: FPU_LATENCY must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("fpu_dot_sequencer: TIMEOUT_CYC must be at least 1");
  end

  seq_state_t       state;
  logic [3:0]       byte_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [6:0]       wr_lsb;
  logic             in_accept;
  logic             wd_expire;
  logic             ser_load;
  logic             ser_done;

  assign in_ready   = (state == IDLE) || (state == LOAD);
  assign in_accept  = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign fpu_launch = (state == ISSUE);
  assign ser_load   = (state == CAPTURE);

  // Byte k lands at bit 127-8k down, i.e. LSB offset 8*(15-k); for a 4-bit
  // counter 15-k is simply ~k.
  assign wr_lsb = {~byte_cnt, 3'b000};

`ifdef FPU_DOT_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expire = (state == LOAD) && !in_accept &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Idle-input cycle counter for LOAD; restarts on every accepted byte.
  always_ff @(posedge clk or posedge write_data_reset) begin
    if (write_data_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wd_expire;
      if ((state != LOAD) || in_accept || wd_expire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Job controller: operand collection, launch, latency wait, capture, send.
  always_ff @(posedge clk or posedge write_data_reset) begin
    if (write_data_reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      lat_cnt      <= '0;
      fpu_operands <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_accept) begin
            fpu_operands[wr_lsb +: 8] <= in_byte;
            byte_cnt                  <= byte_cnt + 4'd1;
            state                     <= LOAD;
          end
        end
        LOAD: begin
          if (in_accept) begin
            fpu_operands[wr_lsb +: 8] <= in_byte;
            byte_cnt                  <= byte_cnt + 4'd1;
            if (byte_cnt == 4'hF) begin
              state <= ISSUE;
            end
          end else if (wd_expire) begin
            fpu_operands <= '0;
            byte_cnt     <= '0;
            state        <= IDLE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_W'(FPU_LATENCY - 1);
          // Leaving WAIT as the count reaches zero makes CAPTURE fall exactly
          // FPU_LATENCY cycles after launch; a latency of 1 needs no WAIT.
          state   <= (FPU_LATENCY > 1) ? WAIT : CAPTURE;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= SEND;
        end
        SEND: begin
          if (ser_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  fpu_seq_byte_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk              (clk),
    .write_data_reset (write_data_reset),
    .load             (ser_load),
    .data             (fpu_result),
    .out_valid        (out_valid),
    .out_byte         (out_byte),
    .out_ready        (out_ready),
    .done             (ser_done)
  );

endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// Self-checking bench for fpu_dot_sequencer with a fixed-latency FPU model.
module tb_fpu_dot_sequencer;

  logic         clk = 1'b0;
  logic         write_data_reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_byte = '0;
  logic         in_ready;
  logic [127:0] fpu_operands;
  logic         fpu_launch;
  logic [31:0]  fpu_result;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         err_timeout;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned launches = 0;
  int unsigned outs = 0;
  int unsigned err_pulses = 0;
  int unsigned jobs_done = 0;
  int unsigned jobs_killed = 0;

  logic         rnd_rdy = 1'b0;
  logic         rdy_force = 1'b1;

  logic [127:0] cur_ops = '0;
  int unsigned  cur_n = 0;
  logic [127:0] exp_jobs[$];
  logic [7:0]   exp_out[$];

  logic         stall_prev = 1'b0;
  logic [7:0]   stall_byte = '0;

  logic [2:0]   lpipe = '0;
  logic [31:0]  rpipe0 = '0, rpipe1 = '0, rpipe2 = '0;

  fpu_dot_sequencer #(
    .WORD_W      (32),
    .N_OPER      (4),
    .FPU_LATENCY (3),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk              (clk),
    .write_data_reset (write_data_reset),
    .in_valid         (in_valid),
    .in_byte          (in_byte),
    .in_ready         (in_ready),
    .fpu_operands     (fpu_operands),
    .fpu_launch       (fpu_launch),
    .fpu_result       (fpu_result),
    .out_valid        (out_valid),
    .out_byte         (out_byte),
    .out_ready        (out_ready),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference FPU: the known test vector gives 10.0; I1 of 0 gives +inf,
  // I1 of 1 gives +0.0; anything else gets a fixed scrambling of the words.
  function automatic logic [31:0] fpu_model(input logic [127:0] ops);
    if (ops == 128'h40800000_3F800000_40400000_40000000) return 32'h41200000;
    if (ops[31:0] == 32'h0) return 32'h7F800000;
    if (ops[31:0] == 32'h1) return 32'h00000000;
    return (ops[31:0] ^ {ops[47:32], ops[63:48]}) + ops[95:64] - ops[127:96];
  endfunction

  // FPU pipeline: result is present only in the cycle FPU_LATENCY after launch.
  always @(posedge clk) begin
    lpipe  <= {lpipe[1:0], fpu_launch};
    rpipe0 <= fpu_model(fpu_operands);
    rpipe1 <= rpipe0;
    rpipe2 <= rpipe1;
  end
  assign fpu_result = lpipe[2] ? rpipe2 : 32'hA5A55A5A;

  // out_ready driver: forced level or random back-pressure.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_data_reset) begin
      stall_prev = 1'b0;
    end else begin
      if (fpu_launch) begin
        logic [127:0] ops;
        logic [31:0]  r;
        launches++;
        if (exp_jobs.size() == 0) begin
          check("launch_unexpected", 1, 0);
        end else begin
          ops = exp_jobs.pop_front();
          check("operands", fpu_operands, ops);
          r = fpu_model(ops);
          for (int j = 0; j < 4; j++) begin
            exp_out.push_back(r[7:0]);
            r = r >> 8;
          end
        end
      end
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_byte", out_byte, stall_byte);
      end
      if (out_valid && out_ready) begin
        outs++;
        if (exp_out.size() == 0) check("out_unexpected", 1, 0);
        else check("out_byte", out_byte, exp_out.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      stall_byte = out_byte;
      if (err_timeout) err_pulses++;
    end
  end

  function automatic void note_byte(input logic [7:0] b);
    cur_ops = {cur_ops[119:0], b};
    cur_n++;
    if (cur_n == 16) begin
      exp_jobs.push_back(cur_ops);
      jobs_done++;
      cur_n = 0;
    end
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int unsigned n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("in_timeout", 0, 1);
    else note_byte(b);
  endtask

  task automatic send_random_job(input int unsigned max_gap);
    for (int k = 0; k < 16; k++) begin
      send_byte(8'($urandom));
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = !busy && exp_out.size() == 0 && exp_jobs.size() == 0;
    end
    @(posedge clk);
    #1;
    check("job_done", ok, 1);
  endtask

  task automatic do_reset();
    write_data_reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_operands", fpu_operands, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_launch", fpu_launch, 0);
    check("rst_err", err_timeout, 0);
    exp_jobs.delete();
    exp_out.delete();
    cur_ops = '0;
    cur_n = 0;
    @(posedge clk);
    #1;
    write_data_reset = 1'b0;
  endtask

  localparam logic [127:0] T1_OPS = 128'h40800000_3F800000_40400000_40000000;

  initial begin
    logic [127:0] v;
    logic [7:0]   b17;
    int unsigned  snap;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1. known vector, launch one cycle after the last byte
    v = T1_OPS;
    for (int k = 0; k < 16; k++) begin
      send_byte(v[127:120]);
      v = v << 8;
    end
    @(negedge clk);
    check("launch_after_last", fpu_launch, 1);
    check("busy_in_issue", busy, 1);
    wait_done();

    // 2. same job with 5 stalled cycles at the start of SEND
    rdy_force = 1'b0;
    v = T1_OPS;
    for (int k = 0; k < 16; k++) begin
      send_byte(v[127:120]);
      v = v << 8;
    end
    for (int c = 0; c < 100 && !out_valid; c++) @(negedge clk);
    check("stall_reached_send", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("stall_first_byte", out_byte, 8'h00);
      @(negedge clk);
    end
    rdy_force = 1'b1;
    wait_done();

    // 3. in_valid held high through the whole busy phase
    send_random_job(0);
    b17 = 8'($urandom);
    in_valid = 1'b1;
    in_byte  = b17;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      check("in_ready_while_busy", in_ready, 0);
    end
    check("idle_reached", busy, 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    note_byte(b17);
    for (int k = 0; k < 15; k++) send_byte(8'($urandom));
    wait_done();

    // 4. reset during WAIT discards the job
    send_random_job(0);
    @(posedge clk);
    #1;
    snap = outs;
    jobs_killed++;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    check("no_out_after_reset", outs, snap);
    send_random_job(1);
    wait_done();

    // 5. stalled partial load
    snap = err_pulses;
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    repeat (300) @(posedge clk);
    #1;
`ifdef FPU_DOT_SEQ_WATCHDOG_EN
    check("wd_pulses", err_pulses - snap, 1);
    check("wd_idle", busy, 0);
    check("wd_operands", fpu_operands, 0);
    cur_ops = '0;
    cur_n = 0;
    send_random_job(0);
`else
    check("nowd_pulses", err_pulses - snap, 0);
    check("nowd_still_loading", busy, 1);
    for (int k = 0; k < 11; k++) send_byte(8'($urandom));
`endif
    wait_done();

    // 6. two back-to-back jobs, then special results
    snap = launches;
    send_random_job(0);
    send_random_job(0);
    wait_done();
    check("b2b_launches", launches - snap, 2);
    for (int s = 0; s < 2; s++) begin
      v = {96'($urandom), 32'(s)};
      v[127:96] = $urandom;
      v[95:64]  = $urandom;
      for (int k = 0; k < 16; k++) begin
        send_byte(v[127:120]);
        v = v << 8;
      end
      wait_done();
    end

    // random back-pressure and input gaps
    rnd_rdy = 1'b1;
    for (int j = 0; j < 4; j++) send_random_job(2);
    wait_done();
    rnd_rdy = 1'b0;

    check("total_launches", launches, jobs_done);
    check("total_outs", outs, 4 * (jobs_done - jobs_killed));
    check("drain_out", exp_out.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
